// File: rtl/sop_pkg.sv
// Shared definitions for the sum-of-products / FIR pipeline: mode encoding
// and the width helpers used to derive address and result widths.
package sop_pkg;

    typedef enum logic {
        MODE_SOP = 1'b0,
        MODE_FIR = 1'b1
    } mode_t;

    // Ceiling log2, usable in constant (parameter) context.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((32'd1 << bits) < value) begin
            bits++;
        end
        return bits;
    endfunction

    // Result width that holds TAPS full-width products without overflow.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        return data_w + coef_w + clog2(taps);
    endfunction

endpackage

// File: rtl/sop_adder_tree.sv
// Combinational balanced adder tree: sums TAPS unsigned operands of IN_W
// bits into an IN_W+clog2(TAPS)-bit result. TAPS must be a power of two.
module sop_adder_tree
    import sop_pkg::*;
#(
    parameter int unsigned TAPS = 4,
    parameter int unsigned IN_W = 8,
    localparam int unsigned OUT_W = IN_W + clog2(TAPS)
) (
    input  logic [TAPS-1:0][IN_W-1:0] operands,
    output logic [OUT_W-1:0]          sum
);

    localparam int unsigned LEVELS = clog2(TAPS);

    // Level l holds TAPS>>l partial sums; each level is its own signal so the
    // tree has no self-referencing array.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned N = TAPS >> l;
        logic [OUT_W-1:0] node [N];
        for (genvar j = 0; j < N; j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign node[j] = OUT_W'(operands[j]);
            end else begin : g_add
                assign node[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/sop_fir_pipe.sv
// Pipelined sum-of-products engine with a writable coefficient file.
// Mode SOP multiplies one sample by every coefficient; mode FIR runs the
// samples through a delay line. Stage 1 registers the products, stage 2
// registers the adder-tree sum; out_valid follows in_valid by two edges.
module sop_fir_pipe
    import sop_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned COEF_W = 4,
    parameter int unsigned TAPS   = 4,
    localparam int unsigned ADDR_W = clog2(TAPS),
    localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mode,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    output logic [ACC_W-1:0]  sum_out
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;

    logic [COEF_W-1:0]           coef   [TAPS];
    logic [DATA_W-1:0]           hist   [TAPS-1];
    logic [DATA_W-1:0]           x_next [TAPS];
    logic [TAPS-1:0][PROD_W-1:0] prod;
    logic                        v1;
    mode_t                       mode_in;
    mode_t                       mode_q;
    logic                        mode_change;
    logic [ACC_W-1:0]            tree_sum;

    assign mode_in     = mode_t'(mode);
    assign mode_change = (mode_in != mode_q);

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        // Tap operand: the current sample in SOP mode or for tap 0; otherwise
        // the delay-line history, seen as zero on the edge the mode switches.
        if (i == 0) begin : g_head
            assign x_next[i] = data_in;
        end else begin : g_tail
            assign x_next[i] = (mode_in == MODE_SOP) ? data_in
                             : (mode_change ? '0 : hist[i-1]);
        end

        // Coefficient file entry; a same-edge sample still multiplies by the old value.
        always_ff @(posedge clk) begin
            if (rst) begin
                coef[i] <= '0;
            end else if (coef_we && (coef_addr == ADDR_W'(i))) begin
                coef[i] <= coef_data;
            end
        end

        // Stage 1: product register for this tap.
        always_ff @(posedge clk) begin
            if (rst) begin
                prod[i] <= '0;
            end else if (in_valid) begin
                prod[i] <= PROD_W'(x_next[i]) * PROD_W'(coef[i]);
            end
        end
    end

    // Delay line: the FIR shift is the operand vector itself (already cleared on a
    // mode switch), so the same path covers shift, switch-and-capture and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS - 1; k++) begin
                hist[k] <= '0;
            end
        end else if (in_valid && (mode_in == MODE_FIR)) begin
            for (int unsigned k = 0; k < TAPS - 1; k++) begin
                hist[k] <= x_next[k];
            end
        end else if (mode_change) begin
            for (int unsigned k = 0; k < TAPS - 1; k++) begin
                hist[k] <= '0;
            end
        end
    end

    // Registered mode, used to detect a switch.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_SOP;
        end else begin
            mode_q <= mode_in;
        end
    end

    sop_adder_tree #(
        .TAPS (TAPS),
        .IN_W (PROD_W)
    ) u_tree (
        .operands (prod),
        .sum      (tree_sum)
    );

    // Stage 2: valid pipe and result register; the result holds between valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            sum_out   <= '0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (v1) begin
                sum_out <= tree_sum;
            end
        end
    end

endmodule

// File: tb/tb_sop_fir_pipe.sv
// Directed, table-driven bench for sop_fir_pipe at default parameters
// (DATA_W=4, COEF_W=4, TAPS=4, ACC_W=10). Each row is driven before a rising
// edge and the outputs expected just after that edge are compared.
module tb_sop_fir_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] data_in;
    logic       mode;
    logic       coef_we;
    logic [1:0] coef_addr;
    logic [3:0] coef_data;
    logic       out_valid;
    logic [9:0] sum_out;

    int checks;
    int failures;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] d;
        logic       m;
        logic       we;
        logic [1:0] a;
        logic [3:0] cd;
        logic       ev;
        logic [9:0] es;
    } vec_t;

    vec_t tbl[$];

    sop_fir_pipe #(
        .DATA_W (4),
        .COEF_W (4),
        .TAPS   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .mode      (mode),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .sum_out   (sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic iv, input logic [3:0] d,
                                input logic m, input logic we, input logic [1:0] a,
                                input logic [3:0] cd, input logic ev, input logic [9:0] es);
        vec_t t;
        t.rst = r; t.iv = iv; t.d = d; t.m = m; t.we = we; t.a = a; t.cd = cd;
        t.ev = ev; t.es = es;
        return t;
    endfunction

    task automatic drive(input logic r, input logic iv, input logic [3:0] d,
                         input logic m, input logic we, input logic [1:0] a,
                         input logic [3:0] cd);
        rst = r; in_valid = iv; data_in = d; mode = m;
        coef_we = we; coef_addr = a; coef_data = cd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [9:0] act,
                       input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input logic ev,
                           input logic [9:0] es);
        chk({tag, "_valid"}, idx, {9'd0, out_valid}, {9'd0, ev});
        chk({tag, "_sum"}, idx, sum_out, es);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 4'd0);

        //            rst iv  d     m   we  a     cd     ev  es
        // reset
        tbl.push_back(mk(1, 0, 4'd0, 0, 0, 2'd0, 4'd0,  0, 10'd0));
        // coefs 1,2,3,4
        tbl.push_back(mk(0, 0, 4'd0, 0, 1, 2'd0, 4'd1,  0, 10'd0));
        tbl.push_back(mk(0, 0, 4'd0, 0, 1, 2'd1, 4'd2,  0, 10'd0));
        tbl.push_back(mk(0, 0, 4'd0, 0, 1, 2'd2, 4'd3,  0, 10'd0));
        tbl.push_back(mk(0, 0, 4'd0, 0, 1, 2'd3, 4'd4,  0, 10'd0));
        // SOP: 5*(1+2+3+4) = 50, then hold
        tbl.push_back(mk(0, 1, 4'd5, 0, 0, 2'd0, 4'd0,  0, 10'd0));
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 2'd0, 4'd0,  1, 10'd50));
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 2'd0, 4'd0,  0, 10'd50));
        // FIR impulse on the switch edge -> 1,2,3,4,0
        tbl.push_back(mk(0, 1, 4'd1, 1, 0, 2'd0, 4'd0,  0, 10'd50));
        tbl.push_back(mk(0, 1, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd1));
        tbl.push_back(mk(0, 1, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd2));
        tbl.push_back(mk(0, 1, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd3));
        tbl.push_back(mk(0, 1, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd4));
        tbl.push_back(mk(0, 0, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd0));
        // FIR gap holds the line: 1, gap, gap, 2 -> [2,1,0,0]=4, 3 -> [3,2,1,0]=10
        tbl.push_back(mk(0, 1, 4'd1, 1, 0, 2'd0, 4'd0,  0, 10'd0));
        tbl.push_back(mk(0, 0, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd1));
        tbl.push_back(mk(0, 0, 4'd0, 1, 0, 2'd0, 4'd0,  0, 10'd1));
        tbl.push_back(mk(0, 1, 4'd2, 1, 0, 2'd0, 4'd0,  0, 10'd1));
        tbl.push_back(mk(0, 1, 4'd3, 1, 0, 2'd0, 4'd0,  1, 10'd4));
        tbl.push_back(mk(0, 0, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd10));
        // fill with 7s: [7,3,2,1]=23, [7,7,3,2]=38, [7,7,7,3]=54, [7,7,7,7]=70
        tbl.push_back(mk(0, 1, 4'd7, 1, 0, 2'd0, 4'd0,  0, 10'd10));
        tbl.push_back(mk(0, 1, 4'd7, 1, 0, 2'd0, 4'd0,  1, 10'd23));
        tbl.push_back(mk(0, 1, 4'd7, 1, 0, 2'd0, 4'd0,  1, 10'd38));
        tbl.push_back(mk(0, 1, 4'd7, 1, 0, 2'd0, 4'd0,  1, 10'd54));
        // switch to SOP with 1 -> 10; back to FIR with 2 -> history cleared -> 2
        tbl.push_back(mk(0, 1, 4'd1, 0, 0, 2'd0, 4'd0,  1, 10'd70));
        tbl.push_back(mk(0, 1, 4'd2, 1, 0, 2'd0, 4'd0,  1, 10'd10));
        tbl.push_back(mk(0, 0, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd2));
        // switch without a sample also clears: then 3 -> [3,0,0,0] = 3
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 2'd0, 4'd0,  0, 10'd2));
        tbl.push_back(mk(0, 0, 4'd0, 1, 0, 2'd0, 4'd0,  0, 10'd2));
        tbl.push_back(mk(0, 1, 4'd3, 1, 0, 2'd0, 4'd0,  0, 10'd2));
        tbl.push_back(mk(0, 0, 4'd0, 1, 0, 2'd0, 4'd0,  1, 10'd3));
        // SOP stream of 2, coef[0]<=9 on the same edge: 2*10=20, then 2*18=36
        tbl.push_back(mk(0, 1, 4'd2, 0, 1, 2'd0, 4'd9,  0, 10'd3));
        tbl.push_back(mk(0, 1, 4'd2, 0, 0, 2'd0, 4'd0,  1, 10'd20));
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 2'd0, 4'd0,  1, 10'd36));
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 2'd0, 4'd0,  0, 10'd36));
        // all coefs 15: 15*60 = 900, then 0
        tbl.push_back(mk(0, 0, 4'd0, 0, 1, 2'd0, 4'd15, 0, 10'd36));
        tbl.push_back(mk(0, 0, 4'd0, 0, 1, 2'd1, 4'd15, 0, 10'd36));
        tbl.push_back(mk(0, 0, 4'd0, 0, 1, 2'd2, 4'd15, 0, 10'd36));
        tbl.push_back(mk(0, 0, 4'd0, 0, 1, 2'd3, 4'd15, 0, 10'd36));
        tbl.push_back(mk(0, 1, 4'd15, 0, 0, 2'd0, 4'd0, 0, 10'd36));
        tbl.push_back(mk(0, 1, 4'd0, 0, 0, 2'd0, 4'd0,  1, 10'd900));
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 2'd0, 4'd0,  1, 10'd0));
        tbl.push_back(mk(0, 0, 4'd0, 0, 0, 2'd0, 4'd0,  0, 10'd0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].m, tbl[i].we, tbl[i].a, tbl[i].cd);
            step();
            chk_out("tbl", i, tbl[i].ev, tbl[i].es);
        end

        // Reset with two samples in flight (coefs all 15): sample 1 emerges as 60,
        // samples 2 and 3 are discarded by reset, coefs are cleared afterwards.
        drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 4'd0);
        step();
        chk_out("rst_seq", 0, 1'b0, 10'd0);
        drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 4'd0);
        step();
        chk_out("rst_seq", 1, 1'b1, 10'd60);
        drive(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 2'd0, 4'd0);
        step();
        chk_out("rst_seq", 2, 1'b0, 10'd0);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        step();
        chk_out("rst_seq", 3, 1'b0, 10'd0);
        drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 2'd0, 4'd0);
        step();
        chk_out("rst_seq", 4, 1'b0, 10'd0);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        step();
        chk_out("rst_seq", 5, 1'b1, 10'd0);

        // Back-to-back write and sample on the last tap: coef[3]<=6 with data 4
        // uses the old 0 -> 0; next sample 4 sees coef[3]=6 -> 24.
        drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 2'd3, 4'd6);
        step();
        chk_out("wr_seq", 0, 1'b0, 10'd0);
        drive(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 2'd0, 4'd0);
        step();
        chk_out("wr_seq", 1, 1'b1, 10'd0);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 4'd0);
        step();
        chk_out("wr_seq", 2, 1'b1, 10'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
